// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg -- shared constants for the button debouncer.
//
// Contents:
//   N_BTN_DEF            default number of button channels
//   DEBOUNCE_CYCLES_DEF  default stable cycles before a level change is taken
//   REPEAT_DELAY_DEF     default cycles from press to first auto-repeat
//   REPEAT_PERIOD_DEF    default cycles between later auto-repeats
//   cnt_width()          counter width wide enough for every timing constant
// ---------------------------------------------------------------------------
package btn_pkg;

  localparam int N_BTN_DEF           = 7;
  localparam int DEBOUNCE_CYCLES_DEF = 250000;    // 10 ms at 25 MHz
  localparam int REPEAT_DELAY_DEF    = 12500000;  // 0.5 s at 25 MHz
  localparam int REPEAT_PERIOD_DEF   = 2500000;   // 0.1 s at 25 MHz

  // One spare bit above $clog2 of the largest constant so the terminal
  // count is always representable and the counters can never wrap.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// ---------------------------------------------------------------------------
// btn_debounce_ch -- one debounced button channel.
//
// The raw level goes through a 2-flop synchronizer, then a counter that
// runs while the synchronized level disagrees with the accepted state and
// clears whenever they agree. Reaching DEBOUNCE_CYCLES-1 while still
// disagreeing flips the accepted state. Press/release pulses are registered
// on the same edge that flips the state, so each is high during the first
// cycle of the new state. With BTN_DEBOUNCE_REPEAT_EN defined, a held button
// re-pulses press after REPEAT_DELAY cycles and then every REPEAT_PERIOD.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset
//   btn_i      raw asynchronous button level, 1 = pressed
//   state_o    debounced level
//   press_o    one-cycle press pulse (and auto-repeat pulses when enabled)
//   release_o  one-cycle release pulse
// ---------------------------------------------------------------------------
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic state_o,
  output logic press_o,
  output logic release_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             state_q, state_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             lvl;
  logic             diff;
  logic             hit;
  logic             rise;
  logic             fall;
  logic             rpt_fire;

  assign lvl  = sync_q[1];
  assign diff = lvl ^ state_q;
  // Accept the change on the edge where the counter already holds the
  // terminal value and the level is still different.
  assign hit  = diff && (cnt_q == DB_LAST);
  assign rise = hit & ~state_q;
  assign fall = hit &  state_q;

  always_comb begin
    cnt_d = '0;
    if (diff && !hit) cnt_d = cnt_q + 1'b1;
  end

  assign state_d   = state_q ^ hit;
  assign press_d   = rise | rpt_fire;
  assign release_d = fall;

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_first_q, rpt_first_d;

  // Timer runs only while the accepted state is 1 and no release is being
  // accepted this cycle, so a repeat never coincides with a release pulse.
  always_comb begin
    rpt_cnt_d   = '0;
    rpt_first_d = 1'b1;
    rpt_fire    = 1'b0;
    if (state_q && !hit) begin
      rpt_first_d = rpt_first_q;
      if (rpt_cnt_q == (rpt_first_q ? RD_LAST : RP_LAST)) begin
        rpt_fire    = 1'b1;
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      state_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_i};
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce -- N_BTN independent debounced button channels.
//
// Optional feature: define BTN_DEBOUNCE_REPEAT_EN to compile in auto-repeat
// of btn_press while a button stays held.
//
// Ports:
//   clk_25mhz    sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   btn          raw button levels, 1 = pressed
//   btn_state    debounced level per button
//   btn_press    one-cycle pulse per accepted press (and per repeat)
//   btn_release  one-cycle pulse per accepted release
//   btn_any      OR of btn_state
// ---------------------------------------------------------------------------
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic             clk_25mhz,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_state,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             btn_any
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk_i     (clk_25mhz),
      .rst_ni    (rst_n),
      .btn_i     (btn[g]),
      .state_o   (btn_state[g]),
      .press_o   (btn_press[g]),
      .release_o (btn_release[g])
    );
  end

  assign btn_any = |btn_state;

endmodule

// File: tb/tb_btn_debounce.sv
module tb_btn_debounce;

  localparam int N = 7;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] btn;
  logic [N-1:0] btn_state;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic         btn_any;

  int n_assert = 0;
  int n_fail   = 0;

  btn_debounce #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk_25mhz   (clk),
    .rst_n       (rst_n),
    .btn         (btn),
    .btn_state   (btn_state),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_any     (btn_any)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge, then settle 1 time unit before sampling/driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input logic [N-1:0] st, input logic [N-1:0] pr,
                         input logic [N-1:0] rl, input logic an);
    chk({tag, ".state"},   btn_state,   st);
    chk({tag, ".press"},   btn_press,   pr);
    chk({tag, ".release"}, btn_release, rl);
    chk({tag, ".any"},     {6'd0, btn_any}, {6'd0, an});
  endtask

  initial begin
    logic exp_p;
    rst_n = 1'b0;
    btn   = '0;
    steps(3);
    chk_all("reset", 7'h00, 7'h00, 7'h00, 1'b0);
    rst_n = 1'b1;
    steps(3);
    chk_all("idle", 7'h00, 7'h00, 7'h00, 1'b0);

    // single press on bit 0: accepted at edge 6
    btn = 7'h01;
    steps(5);
    chk_all("p0.e5", 7'h00, 7'h00, 7'h00, 1'b0);
    step();
    chk_all("p0.e6", 7'h01, 7'h01, 7'h00, 1'b1);
    step();
    chk_all("p0.e7", 7'h01, 7'h00, 7'h00, 1'b1);
    btn = 7'h00;
    steps(5);
    chk_all("r0.e5", 7'h01, 7'h00, 7'h00, 1'b1);
    step();
    chk_all("r0.e6", 7'h00, 7'h00, 7'h01, 1'b0);
    step();
    chk_all("r0.e7", 7'h00, 7'h00, 7'h00, 1'b0);

    // 3-cycle glitch on bit 1 must be ignored
    btn = 7'h02;
    steps(3);
    btn = 7'h00;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all("glitch", 7'h00, 7'h00, 7'h00, 1'b0);
    end

    // all bits together
    btn = 7'h7F;
    steps(5);
    chk_all("all.e5", 7'h00, 7'h00, 7'h00, 1'b0);
    step();
    chk_all("all.e6", 7'h7F, 7'h7F, 7'h00, 1'b1);
    step();
    chk_all("all.e7", 7'h7F, 7'h00, 7'h00, 1'b1);
    steps(13);
    btn = 7'h00;
    steps(5);
    chk("allr.e5.state", btn_state, 7'h7F);
    chk("allr.e5.rel",   btn_release, 7'h00);
    step();
    chk_all("allr.e6", 7'h00, 7'h00, 7'h7F, 1'b0);
    step();
    chk_all("allr.e7", 7'h00, 7'h00, 7'h00, 1'b0);

    // reset in the middle of a press on bit 2 while bit 0 is accepted
    btn = 7'h01;
    steps(6);
    chk_all("pre.e6", 7'h01, 7'h01, 7'h00, 1'b1);
    btn = 7'h05;
    steps(2);
    #1 rst_n = 1'b0;
    #2;
    chk_all("async_rst", 7'h00, 7'h00, 7'h00, 1'b0);
    steps(2);
    btn = 7'h04;
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk_all("post_rst", 7'h00, 7'h00, 7'h00, 1'b0);
    end
    step();
    chk_all("post_rst.e6", 7'h04, 7'h04, 7'h00, 1'b1);
    step();
    chk_all("post_rst.e7", 7'h04, 7'h00, 7'h00, 1'b1);

    // hold bit 3 long: auto-repeat only when compiled in
    btn = 7'h00;
    steps(8);
    chk_all("clr", 7'h00, 7'h00, 7'h00, 1'b0);
    btn = 7'h08;
    steps(6);
    chk_all("hold.e6", 7'h08, 7'h08, 7'h00, 1'b1);
    for (int k = 1; k <= 30; k++) begin
      step();
`ifdef BTN_DEBOUNCE_REPEAT_EN
      exp_p = (k == 10) || (k > 10 && ((k - 10) % 3) == 0);
`else
      exp_p = 1'b0;
`endif
      chk("hold.press", btn_press, {3'b000, exp_p, 3'b000});
      chk("hold.state", btn_state, 7'h08);
    end
    btn = 7'h00;
    steps(6);
    chk_all("hold.rel", 7'h00, 7'h00, 7'h08, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter N_BTN, default 7, number of button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 250000, consecutive stable cycles required to accept a change (10 ms at 25 MHz).
REQ-003 SHALL have parameter REPEAT_DELAY, default 12500000, cycles from press to first auto-repeat (0.5 s).
REQ-004 SHALL have parameter REPEAT_PERIOD, default 2500000, cycles between subsequent auto-repeats (0.1 s).
REQ-005 SHALL have port clk_25mhz  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port btn  input  N_BTN  raw asynchronous button levels, 1 = pressed.
REQ-008 SHALL have port btn_state  output  N_BTN  debounced level per button.
REQ-009 SHALL have port btn_press  output  N_BTN  one-cycle pulse per accepted press (and per repeat when enabled).
REQ-010 SHALL have port btn_release  output  N_BTN  one-cycle pulse per accepted release.
REQ-011 SHALL have port btn_any  output  1  OR of btn_state.

Function
REQ-012 Each btn bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Per channel, a counter SHALL increment each cycle the synchronized level differs from btn_state and clear to 0 in any cycle it equals btn_state.
REQ-014 When the counter reaches DEBOUNCE_CYCLES-1 with the level still differing, btn_state SHALL toggle on that edge and the counter SHALL clear.
REQ-015 Latency: a clean input change held stable SHALL appear on btn_state exactly DEBOUNCE_CYCLES+2 rising edges after the first edge sampling it.
REQ-016 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no change on btn_state, btn_press or btn_release.
REQ-017 btn_press SHALL be high for exactly the one cycle after btn_state rises 0->1 (registered edge detect); btn_release likewise for 1->0.
REQ-018 btn_press and btn_release for the same channel SHALL never be high in the same cycle.
REQ-019 Channels SHALL be fully independent; simultaneous changes on several bits SHALL each be debounced and pulsed in the same cycles.
REQ-020 Counter width SHALL be $clog2(max of DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1 bits and SHALL never wrap.
REQ-021 btn_any SHALL be combinational OR of registered btn_state.

Reset
REQ-022 On rst_n low, synchronizers, counters, btn_state, btn_press, btn_release and btn_any SHALL clear to 0 immediately, independent of clock.
REQ-023 Reset asserted mid-debounce SHALL discard progress; no press/release pulse SHALL be generated by reset assertion or deassertion.
REQ-024 A button held through reset release SHALL be accepted after the full REQ-015 latency, producing one btn_press.

Configuration
REQ-025 Macro BTN_DEBOUNCE_REPEAT_EN SHALL compile in auto-repeat: while btn_state bit stays 1, btn_press SHALL re-pulse REPEAT_DELAY cycles after the initial press pulse, then every REPEAT_PERIOD cycles; repeat timer clears on release or reset.
REQ-026 Without BTN_DEBOUNCE_REPEAT_EN, btn_press SHALL pulse only on 0->1 of btn_state; REPEAT_DELAY and REPEAT_PERIOD SHALL be accepted but unused, and no repeat timer logic SHALL be synthesized.

Structure
REQ-027 Package btn_pkg SHALL hold N_BTN default, default cycle constants and the counter-width function.
REQ-028 Per-channel logic SHALL be sub-module btn_debounce_ch (synchronizer, counter, state, edge pulses, optional repeat), instantiated N_BTN times via generate.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-029 btn=7'h01 held from cycle 0 -> btn_state[0]=1 at edge 6, btn_press[0]=1 for exactly one cycle, btn_any=1, other bits 0.
REQ-030 btn[1] high for 3 cycles then low -> btn_state, btn_press, btn_release all remain 0.
REQ-031 btn 7'h7F then 7'h00 after 20 cycles -> all press bits pulse together once; all release bits pulse together once, 6 edges after the fall.
REQ-032 rst_n pulsed low during a 2-cycle-old press on btn[2] -> outputs 0 asynchronously; with btn[2] still held, single btn_press[2] 6 edges after rst_n rises.
REQ-033 With BTN_DEBOUNCE_REPEAT_EN, btn[3] held 30 cycles past acceptance -> btn_press[3] pulses at +0, +10, +13, +16, ... cycles; without the macro -> only the +0 pulse.
